// File: rtl/fifo_pixel_unpacker.sv
// fifo_pixel_unpacker: pops bytes from a FWFT FIFO and emits tagged pixel words on a valid/ready stream.
// Optional FIFO_UNPACK_STATS_EN adds ufl_cnt, a saturating count of cycles starved mid-pixel.
module fifo_pixel_unpacker #(
  parameter int DATA_WIDTH    = 8,
  parameter int BYTES_PER_PIX = 3,
  parameter int H_ACTIVE      = 1280,
  parameter int V_ACTIVE      = 720
) (
  input  logic                                rd_clk,
  input  logic                                rd_rst_n,
  input  logic                                sync_clr,
  input  logic                                rd_vld,
  input  logic [DATA_WIDTH-1:0]               rd_data,
  output logic                                rd_en,
  output logic                                pix_valid,
  input  logic                                pix_ready,
  output logic [DATA_WIDTH*BYTES_PER_PIX-1:0] pix_data,
  output logic                                pix_sol,
  output logic                                pix_eol,
  output logic                                pix_sof,
  output logic                                pix_eof
`ifdef FIFO_UNPACK_STATS_EN
  , output logic [15:0]                       ufl_cnt
`endif
);
  localparam int PW = DATA_WIDTH*BYTES_PER_PIX;
  localparam int AW = PW-DATA_WIDTH;
  localparam int BW = BYTES_PER_PIX > 2 ? $clog2(BYTES_PER_PIX) : 1;
  localparam int XW = H_ACTIVE > 2 ? $clog2(H_ACTIVE) : 1;
  localparam int YW = V_ACTIVE > 2 ? $clog2(V_ACTIVE) : 1;
  logic [BW-1:0] r_byte_cnt;
  logic [AW-1:0] r_asm;
  logic [PW-1:0] r_data, w_cat;
  logic [XW-1:0] r_x, w_xn, w_x;
  logic [YW-1:0] r_y, w_yn, w_y;
  logic          r_valid, r_sol, r_eol, r_sof, r_eof;
  logic          w_last, w_free, w_load, w_acc, w_xend;
  always_comb begin
    w_last = r_byte_cnt == BW'(BYTES_PER_PIX-1);
    w_free = !r_valid || pix_ready;
    rd_en  = rd_rst_n && rd_vld && !sync_clr && (!w_last || w_free);
    w_load = rd_en && w_last;
    w_acc  = r_valid && pix_ready;
    w_cat  = {r_asm, rd_data};
    w_xend = r_x == XW'(H_ACTIVE-1);
    w_xn   = w_xend ? '0 : r_x + XW'(1);
    w_yn   = !w_xend ? r_y : (r_y == YW'(V_ACTIVE-1)) ? '0 : r_y + YW'(1);
    // A pixel loading in the same cycle as an acceptance takes the position after the accepted one
    w_x    = w_acc ? w_xn : r_x;
    w_y    = w_acc ? w_yn : r_y;
  end
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_data     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_valid    <= 1'b0;
      r_sol      <= 1'b0;
      r_eol      <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
    end else if (sync_clr) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (rd_en) begin
        r_asm      <= w_cat[AW-1:0];
        r_byte_cnt <= w_last ? '0 : r_byte_cnt + BW'(1);
      end
      if (w_acc) begin
        r_x <= w_xn;
        r_y <= w_yn;
      end
      if (w_load) begin
        r_data <= w_cat;
        r_sol  <= w_x == '0;
        r_eol  <= w_x == XW'(H_ACTIVE-1);
        r_sof  <= w_x == '0 && w_y == '0;
        r_eof  <= w_x == XW'(H_ACTIVE-1) && w_y == YW'(V_ACTIVE-1);
      end
      r_valid <= w_load || (r_valid && !pix_ready);
    end
  end
`ifdef FIFO_UNPACK_STATS_EN
  logic [15:0] r_ufl;
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) r_ufl <= '0;
    else if (sync_clr) r_ufl <= '0;
    else if (r_byte_cnt != '0 && !rd_vld && r_ufl != 16'hFFFF) r_ufl <= r_ufl + 16'd1;
  end
  assign ufl_cnt = r_ufl;
`endif
  assign pix_valid = r_valid;
  assign pix_data  = r_data;
  assign pix_sol   = r_sol;
  assign pix_eol   = r_eol;
  assign pix_sof   = r_sof;
  assign pix_eof   = r_eof;
endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
// tb_fifo_pixel_unpacker: directed vector table plus hand sequences for frame wrap, stats and async reset.
module tb_fifo_pixel_unpacker;
  logic        clk = 1'b0;
  logic        rst_n, sync_clr, rd_vld, rd_en, pix_valid, pix_ready;
  logic        pix_sol, pix_eol, pix_sof, pix_eof;
  logic [7:0]  rd_data;
  logic [23:0] pix_data;
`ifdef FIFO_UNPACK_STATS_EN
  logic [15:0] ufl_cnt;
`endif
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  fifo_pixel_unpacker #(.DATA_WIDTH(8), .BYTES_PER_PIX(3), .H_ACTIVE(4), .V_ACTIVE(2)) dut (
    .rd_clk(clk), .rd_rst_n(rst_n), .sync_clr(sync_clr), .rd_vld(rd_vld), .rd_data(rd_data),
    .rd_en(rd_en), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_eof(pix_eof)
`ifdef FIFO_UNPACK_STATS_EN
    , .ufl_cnt(ufl_cnt)
`endif
  );
  typedef struct {
    logic rst, clr, vld; logic [7:0] d; logic rdy;
    logic en, pv; logic [23:0] pd; logic sol, eol, sof, eof;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic rst, clr, vld, input logic [7:0] d, input logic rdy,
                     input logic en, pv, input logic [23:0] pd, input logic sol, eol, sof, eof);
    vq.push_back('{rst, clr, vld, d, rdy, en, pv, pd, sol, eol, sof, eof});
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] bv(input int c);
    return 8'(c*7+1);
  endfunction
  initial begin
    int n;
    logic [23:0] ed;
    int p, x, y;
    rst_n = 1'b0; sync_clr = 1'b0; rd_vld = 1'b0; rd_data = '0; pix_ready = 1'b0;
    //  rst clr vld data  rdy   en pv data       sol eol sof eof
    add(0, 0, 1, 8'hAA, 1,    0, 0, 24'h0,      0, 0, 0, 0);
    add(0, 0, 1, 8'hAA, 1,    0, 0, 24'h0,      0, 0, 0, 0);
    add(1, 0, 1, 8'h11, 1,    1, 0, 24'h0,      0, 0, 0, 0);
    add(1, 0, 1, 8'h22, 1,    1, 0, 24'h0,      0, 0, 0, 0);
    add(1, 0, 1, 8'h33, 1,    1, 0, 24'h0,      0, 0, 0, 0);
    add(1, 0, 0, 8'h00, 1,    0, 1, 24'h112233, 1, 0, 1, 0);
    add(1, 0, 0, 8'h00, 1,    0, 0, 24'h112233, 1, 0, 1, 0);
    add(1, 0, 1, 8'h44, 0,    1, 0, 24'h112233, 1, 0, 1, 0);
    add(1, 0, 1, 8'h55, 0,    1, 0, 24'h112233, 1, 0, 1, 0);
    add(1, 0, 1, 8'h66, 0,    1, 0, 24'h112233, 1, 0, 1, 0);
    add(1, 0, 1, 8'h77, 0,    1, 1, 24'h445566, 0, 0, 0, 0);
    add(1, 0, 1, 8'h88, 0,    1, 1, 24'h445566, 0, 0, 0, 0);
    add(1, 0, 1, 8'h99, 0,    0, 1, 24'h445566, 0, 0, 0, 0);
    add(1, 0, 1, 8'h99, 0,    0, 1, 24'h445566, 0, 0, 0, 0);
    add(1, 0, 1, 8'h99, 1,    1, 1, 24'h445566, 0, 0, 0, 0);
    add(1, 0, 0, 8'h00, 1,    0, 1, 24'h778899, 0, 0, 0, 0);
    add(1, 0, 0, 8'h00, 0,    0, 0, 24'h778899, 0, 0, 0, 0);
    add(1, 0, 1, 8'h01, 1,    1, 0, 24'h778899, 0, 0, 0, 0);
    add(1, 0, 1, 8'h02, 1,    1, 0, 24'h778899, 0, 0, 0, 0);
    add(1, 0, 1, 8'h03, 1,    1, 0, 24'h778899, 0, 0, 0, 0);
    add(1, 0, 1, 8'h04, 1,    1, 1, 24'h010203, 0, 1, 0, 0);
    add(1, 0, 1, 8'h05, 1,    1, 0, 24'h010203, 0, 1, 0, 0);
    add(1, 0, 1, 8'h06, 1,    1, 0, 24'h010203, 0, 1, 0, 0);
    add(1, 0, 0, 8'h00, 0,    0, 1, 24'h040506, 1, 0, 0, 0);
    add(1, 0, 1, 8'hE1, 0,    1, 1, 24'h040506, 1, 0, 0, 0);
    add(1, 0, 1, 8'hE2, 0,    1, 1, 24'h040506, 1, 0, 0, 0);
    add(1, 1, 1, 8'hE3, 0,    0, 1, 24'h040506, 1, 0, 0, 0);
    add(1, 0, 1, 8'hA1, 1,    1, 0, 24'h040506, 1, 0, 0, 0);
    add(1, 0, 1, 8'hA2, 1,    1, 0, 24'h040506, 1, 0, 0, 0);
    add(1, 0, 1, 8'hA3, 1,    1, 0, 24'h040506, 1, 0, 0, 0);
    add(1, 0, 0, 8'h00, 1,    0, 1, 24'hA1A2A3, 1, 0, 1, 0);
    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst; sync_clr = vq[i].clr; rd_vld = vq[i].vld; rd_data = vq[i].d; pix_ready = vq[i].rdy;
      #1;
      chk($sformatf("row%0d_rd_en", i), 32'(rd_en), 32'(vq[i].en));
      chk($sformatf("row%0d_valid", i), 32'(pix_valid), 32'(vq[i].pv));
      chk($sformatf("row%0d_data", i), 32'(pix_data), 32'(vq[i].pd));
      chk($sformatf("row%0d_marks", i), {28'd0, pix_sol, pix_eol, pix_sof, pix_eof},
          {28'd0, vq[i].sol, vq[i].eol, vq[i].sof, vq[i].eof});
    end
    // Full-rate frame: positions 1..7 of the current frame, then position 0 of the next
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rd_vld = c < 24; rd_data = bv(c); pix_ready = 1'b1;
      #1;
      chk($sformatf("frame_c%0d_rd_en", c), 32'(rd_en), 32'(c < 24));
      if (pix_valid) begin
        p = (1 + n) % 8; x = p % 4; y = p / 4;
        ed = {bv(3*n), bv(3*n+1), bv(3*n+2)};
        chk($sformatf("frame_px%0d_data", n), 32'(pix_data), 32'(ed));
        chk($sformatf("frame_px%0d_marks", n), {28'd0, pix_sol, pix_eol, pix_sof, pix_eof},
            {28'd0, x == 0, x == 3, x == 0 && y == 0, x == 3 && y == 1});
        n++;
      end
    end
    chk("frame_pixel_count", 32'(n), 32'd8);
`ifdef FIFO_UNPACK_STATS_EN
    @(negedge clk); sync_clr = 1'b1; rd_vld = 1'b0;
    @(negedge clk); sync_clr = 1'b0; rd_vld = 1'b1; rd_data = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rd_vld = 1'b0;
    end
    @(negedge clk); #1;
    chk("ufl_cnt_starved", 32'(ufl_cnt), 32'd10);
    sync_clr = 1'b1;
    @(negedge clk); sync_clr = 1'b0; #1;
    chk("ufl_cnt_cleared", 32'(ufl_cnt), 32'd0);
`endif
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rd_vld = 1'b1; rd_data = 8'(8'hC0 + i);
    end
    @(negedge clk); rd_vld = 1'b1; rd_data = 8'hD0; #1;
    chk("pre_reset_valid", 32'(pix_valid), 32'd1);
    chk("pre_reset_data", 32'(pix_data), 32'hC0C1C2);
    #1 rst_n = 1'b0; #1;
    chk("async_reset_valid", 32'(pix_valid), 32'd0);
    chk("async_reset_rd_en", 32'(rd_en), 32'd0);
    chk("async_reset_data", 32'(pix_data), 32'd0);
    @(negedge clk); rst_n = 1'b1; pix_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_vld = 1'b1; rd_data = 8'(8'hB0 + i);
      @(negedge clk);
    end
    rd_vld = 1'b0; #1;
    chk("post_reset_valid", 32'(pix_valid), 32'd1);
    chk("post_reset_data", 32'(pix_data), 32'hB0B1B2);
    chk("post_reset_sof", {30'd0, pix_sof, pix_sol}, 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
